// File: rtl/psum_requant.sv
// psum_requant: accumulates signed partial sums per output pixel, adds a
// per-channel bias, then round-half-up arithmetic right shift.
// Ports:
//   clk, rst             clock, async active-high reset
//   cfg_len, cfg_shift   beats-1 and shift amount, latched on first beat
//   in_valid/in_ready    partial-sum beat handshake (in_psum, in_bias)
//   out_valid/out_ready  result handshake (out_data, wide and unsaturated)
module psum_requant #(
    parameter int PSUM_DW = 20,
    parameter int BIAS_DW = 16,
    parameter int ACC_DW  = 32,
    parameter int CNT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     cfg_len,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PSUM_DW-1:0]   in_psum,
    input  logic [BIAS_DW-1:0]   in_bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_DW-1:0]    out_data
);

    typedef enum logic [1:0] {
        S_ACC,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [ACC_DW-1:0]    acc_q, acc_d;
    logic [ACC_DW-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;

    logic [ACC_DW-1:0]    psum_x;
    logic [ACC_DW-1:0]    bias_x;
    logic [CNT_W-1:0]     len_eff;

    // Rounding is done one bit wider so adding the half-LSB never overflows.
    logic signed [ACC_DW:0] acc_w;
    logic signed [ACC_DW:0] rnd_w;
    logic signed [ACC_DW:0] sum_w;
    logic signed [ACC_DW:0] shr_w;

    assign psum_x = {{(ACC_DW-PSUM_DW){in_psum[PSUM_DW-1]}}, in_psum};
    assign bias_x = {{(ACC_DW-BIAS_DW){in_bias[BIAS_DW-1]}}, in_bias};

    // On the first beat the live config is the one being latched.
    assign len_eff = (cnt_q == '0) ? cfg_len : len_q;

    assign acc_w = {acc_q[ACC_DW-1], acc_q};
    assign rnd_w = (shift_q == '0) ? '0
                 : ((ACC_DW+1)'(1) << (shift_q - SHIFT_W'(1)));
    assign sum_w = acc_w + rnd_w;
    assign shr_w = sum_w >>> shift_q;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        len_d   = cfg_len;
                        shift_d = cfg_shift;
                        acc_d   = bias_x + psum_x;
                    end else begin
                        acc_d   = acc_q + psum_x;
                    end
                    if (cnt_q == len_eff) begin
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                data_d  = ACC_DW'(shr_w);
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_psum_requant.sv
// tb_psum_requant: scenario tasks plus randomized groups checked against
// an arithmetic reference model of accumulate, bias and rounded shift.
module tb_psum_requant;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_len = '0;
    logic [4:0]  cfg_shift = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_psum = '0;
    logic [15:0] in_bias = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    psum_requant dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference: exact sum wrapped to 32 bits, then floor((a + 2^(s-1)) / 2^s).
    function automatic logic [31:0] model(input int bias, input int ps[$],
                                          input int sh);
        longint a;
        longint r;
        int     w;
        a = bias;
        foreach (ps[i]) a += ps[i];
        w = int'(a);
        a = w;
        if (sh == 0) r = a;
        else r = (a + (64'sd1 <<< (sh - 1))) >>> sh;
        return r[31:0];
    endfunction

    task automatic beat(input int p, input int b);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_psum  = p[19:0];
        in_bias  = b[15:0];
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL beat_accept: in_ready never high in %0d cycles", n);
        end
    endtask

    task automatic take_out(input logic [31:0] exp, input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!out_valid || out_data !== exp) begin
            n_fail++;
            $display("FAIL %s: out_valid=%0b out_data=%h expected %h",
                     name, out_valid, out_data, exp);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%0b in_ready=%0b expected 0 1",
                     name, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%0b data=%h ready=%0b expected 0 0 1",
                     out_valid, out_data, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int ps[$];
        ps = '{100, -20, 50, 7};
        cfg_len = 8'd3;
        cfg_shift = 5'd2;
        foreach (ps[i]) beat(ps[i], 10);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_shift_cycle: valid=%0b ready=%0b expected 0 0",
                     out_valid, in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h25) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%0b data=%h expected 1 00000025",
                     out_valid, out_data);
        end
        @(posedge clk);
        #1;
        take_out(32'h25, "basic");
    endtask

    task automatic test_neg_round();
        cfg_len = 8'd1;
        cfg_shift = 5'd1;
        beat(-5, 0);
        beat(-2, 0);
        take_out(32'hFFFF_FFFD, "neg_round");
    endtask

    task automatic test_single();
        cfg_len = 8'd0;
        cfg_shift = 5'd0;
        beat(32'h7FFFF, -1);
        take_out(32'h0007_FFFE, "single_beat");
    endtask

    task automatic test_backpressure();
        int ps2[$];
        ps2 = '{1, 2, 3, 4, 5};
        cfg_len = 8'd3;
        cfg_shift = 5'd2;
        beat(100, 10);
        beat(-20, 10);
        beat(50, 10);
        beat(7, 10);
        cfg_len = 8'd4;
        cfg_shift = 5'd0;
        in_valid = 1'b1;
        in_psum = 20'd1;
        in_bias = 16'd100;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h25 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%0b data=%h ready=%0b expected 1 00000025 0",
                         i, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        foreach (ps2[i]) beat(ps2[i], 100);
        take_out(model(100, ps2, 0), "after_hold");
    endtask

    task automatic test_cfg_change();
        int ps[$];
        ps = '{1, 2, 3, 4};
        cfg_len = 8'd3;
        cfg_shift = 5'd0;
        beat(ps[0], 0);
        cfg_len = 8'd1;
        cfg_shift = 5'd3;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_midgroup_%0d: ready=%0b valid=%0b expected 1 0",
                         i, in_ready, out_valid);
            end
            @(posedge clk);
            #1;
            beat(ps[i], 0);
        end
        take_out(32'd10, "cfg_len_latched");
        beat(16, 0);
        beat(8, 0);
        take_out(32'd3, "cfg_next_group");
    endtask

    task automatic test_reset_mid();
        cfg_len = 8'd3;
        cfg_shift = 5'd0;
        beat(1000, 55);
        beat(2000, 55);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b data=%h ready=%0b expected 0 0 1",
                     out_valid, out_data, in_ready);
        end
        @(posedge clk);
        #1;
        cfg_len = 8'd1;
        beat(3, 0);
        beat(4, 0);
        take_out(32'd7, "reset_fresh_group");
    endtask

    task automatic test_random();
        for (int g = 0; g < 25; g++) begin
            int ps[$];
            int len;
            int sh;
            int bias;
            logic signed [19:0] p20;
            logic signed [15:0] b16;
            ps = {};
            len = int'($urandom_range(0, 5));
            sh = int'($urandom_range(0, 31));
            b16 = 16'($urandom);
            bias = int'(b16);
            for (int i = 0; i <= len; i++) begin
                p20 = 20'($urandom);
                ps.push_back(int'(p20));
            end
            cfg_len = len[7:0];
            cfg_shift = sh[4:0];
            for (int i = 0; i <= len; i++) begin
                if (i == 0) beat(ps[i], bias);
                else beat(ps[i], int'($urandom));
                if (i == 0) begin
                    cfg_len = 8'($urandom);
                    cfg_shift = 5'($urandom);
                end
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            take_out(model(bias, ps, sh), $sformatf("random_%0d", g));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_round();
        test_single();
        test_backpressure();
        test_cfg_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
